// File: rtl/log_mult_pkg.sv
// rtl/log_mult_pkg.sv - shared constants, helpers and stage payload for log_mult_pipe
package log_mult_pkg;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  // Payload fields are sized for the largest supported configuration (N=32, TAG_W<=16)
  localparam int K_MAX_W   = 6;
  localparam int F_MAX_W   = 32;
  localparam int TAG_MAX_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

  typedef struct packed {
    logic [K_MAX_W-1:0]   k;
    logic [F_MAX_W-1:0]   f;
    logic                 c;
    logic                 z;
    logic                 mode;
    logic [TAG_MAX_W-1:0] tag;
  } stage_t;

endpackage

// File: rtl/log_mult_pipe_lod_enc.sv
// rtl/log_mult_pipe_lod_enc.sv - leading-one detector and W-bit fraction truncator
module lod_enc
  import log_mult_pkg::*;
#(
  parameter int N  = 16,
  parameter int W  = 6,
  parameter int KW = clog2(N)
) (
  input  logic [N-1:0]  x,
  output logic [KW-1:0] k,
  output logic [W-1:0]  f
);

  logic [N-1:0]  rem;
  logic [N-1:0]  aligned;
  logic [KW-1:0] sh;

  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++)
      if (x[i]) k = KW'(i);
  end

  // Drop the leading one, then left-align the remainder into N-1 bits and keep the top W
  assign rem     = x & ~(N'(1) << k);
  assign sh      = KW'(N - 1) - k;
  assign aligned = rem << sh;
  assign f       = W'(aligned >> (N - 1 - W));

endmodule

// File: rtl/log_mult_pipe.sv
// rtl/log_mult_pipe.sv - four-stage pipelined Mitchell/exact unsigned multiplier
module log_mult_pipe
  import log_mult_pkg::*;
#(
  parameter int N     = 16,
  parameter int W     = 6,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_y,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mode
);

  localparam int KW   = clog2(N);
  localparam int H    = N / 2;
  localparam int PL_W = N + H;
  localparam int PH_W = 2 * N - H;
  localparam int P_W  = 2 * N;
  localparam int SC_W = 2 * N + W;

  logic v1, v2, v3, v4;
  logic ld1, ld2, ld3, ld4;

  // A stage loads whenever it is empty or its contents move on, so bubbles collapse
  assign ld4       = !v4 || out_ready;
  assign ld3       = !v3 || ld4;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v4;

  logic [N-1:0]     x1, y1;
  logic             z1, m1;
  logic [TAG_W-1:0] t1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      z1 <= 1'b0;
      m1 <= 1'b0;
      t1 <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        x1 <= in_x;
        y1 <= in_y;
        z1 <= (in_x == '0) || (in_y == '0);
        m1 <= in_mode;
        t1 <= in_tag;
      end
    end
  end

  logic [KW-1:0] ka, kb;
  logic [W-1:0]  fa, fb;

  lod_enc #(.N(N), .W(W)) u_lod_x (.x(x1), .k(ka), .f(fa));
  lod_enc #(.N(N), .W(W)) u_lod_y (.x(y1), .k(kb), .f(fb));

  logic [KW-1:0]    k2a, k2b;
  logic [W-1:0]     f2a, f2b;
  logic [PL_W-1:0]  pl2;
  logic [PH_W-1:0]  ph2;
  logic             z2, m2;
  logic [TAG_W-1:0] t2;

  // Exact product is split into low/high half partial products here, combined in S3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      k2a <= '0;
      k2b <= '0;
      f2a <= '0;
      f2b <= '0;
      pl2 <= '0;
      ph2 <= '0;
      z2  <= 1'b0;
      m2  <= 1'b0;
      t2  <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        k2a <= ka;
        k2b <= kb;
        f2a <= fa;
        f2b <= fb;
        pl2 <= PL_W'(x1) * PL_W'(y1[H-1:0]);
        ph2 <= PH_W'(x1) * PH_W'(y1[N-1:H]);
        z2  <= z1;
        m2  <= m1;
        t2  <= t1;
      end
    end
  end

  logic [W:0]     sum;
  stage_t         s3_d, s3_q;
  logic [P_W-1:0] prod3;

  assign sum = {1'b0, f2a} + {1'b0, f2b};

  always_comb begin
    s3_d      = '0;
    s3_d.k    = K_MAX_W'(k2a) + K_MAX_W'(k2b);
    s3_d.f    = F_MAX_W'(sum[W-1:0]);
    s3_d.c    = sum[W];
    s3_d.z    = z2;
    s3_d.mode = m2;
    s3_d.tag  = TAG_MAX_W'(t2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3    <= 1'b0;
      s3_q  <= '0;
      prod3 <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        s3_q  <= s3_d;
        prod3 <= P_W'(pl2) + (P_W'(ph2) << H);
      end
    end
  end

  logic [K_MAX_W-1:0] sh;
  logic [SC_W-1:0]    scaled;
  logic [P_W-1:0]     p_d;
  logic               unused_bits;

  // Mitchell antilog: (1.fr) * 2^(k+c), computed with W extra low bits then floored
  assign sh          = s3_q.k + K_MAX_W'(s3_q.c);
  assign scaled      = SC_W'({1'b1, s3_q.f[W-1:0]}) << sh;
  assign unused_bits = ^{s3_q, scaled};

  always_comb begin
    p_d = '0;
    if (!s3_q.z) begin
      case (s3_q.mode)
        MODE_APPROX: p_d = scaled[SC_W-1:W];
        MODE_EXACT:  p_d = prod3;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v4       <= 1'b0;
      out_p    <= '0;
      out_tag  <= '0;
      out_mode <= 1'b0;
    end else if (ld4) begin
      v4 <= v3;
      if (v3) begin
        out_p    <= p_d;
        out_tag  <= s3_q.tag[TAG_W-1:0];
        out_mode <= s3_q.mode;
      end
    end
  end

endmodule

// File: doc/log_mult_pipe.md
Name: log_mult_pipe

Overview:
- Parametrised, pipelined successor to the registered approximate multiplier top.
- Computes an unsigned N×N product per transaction. The mode is selected per transaction:
  - Mitchell logarithmic approximation with fraction truncated to W bits, or
  - exact product.
- Four-stage pipeline with valid/ready handshake, bubble collapsing, full throughput and per-transaction tag passthrough.
- Sits between operand source and accumulator/consumer in the approximate-arithmetic datapath.

Parameters:
- N, 16, operand width in bits (4..32)
- W, 6, retained fraction bits in approximate mode (1..N-1)
- TAG_W, 4, width of sideband tag carried with each transaction

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  pipeline can accept this cycle
- in_x  in  N  operand X, unsigned
- in_y  in  N  operand Y, unsigned
- in_mode  in  1  0 = Mitchell approximate, 1 = exact
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  2N  product
- out_tag  out  TAG_W  tag of that product
- out_mode  out  1  mode of that product

Behaviour:
- Reset (async assert, sync release by system):
  - all stage valids 0, so out_valid = 0.
  - out_p = 0, out_tag = 0, out_mode = 0.
  - in_ready = 1 on the first cycle after release.
- Handshake:
  - A transfer occurs on a clk edge with valid && ready.
  - in_ready is combinational: in_ready = !v1 || adv1.
  - A stage advances (adv_s) when it is empty, or when the next stage is empty or advancing.
  - Stage 4 advances when !v4 || out_ready.
  - Held outputs stay stable while out_valid && !out_ready.
- Latency: exactly 4 cycles from accepted input to out_valid when never stalled. Throughput is 1 per cycle.
- Bubbles collapse: an empty stage is filled even if downstream stages are stalled.
- Stages:
  - S1 registers the operands and computes the zero flag z = (x == 0 || y == 0).
  - S1 also runs leading-one detect: k1 = floor(log2 x), k2 = floor(log2 y).
  - S2 forms each fraction as (x - 2^k1) left-aligned to N-1 bits, truncated (floor) to the W MSBs, giving f1, f2. The exact path computes x*y, with the multiply split across S2/S3.
  - S3 computes sum = f1 + f2 (W+1 bits), carry c = sum[W], fr = sum[W-1:0], and k = k1 + k2.
  - S4 registers the result:
    - approximate: P = ((2^W + fr) << (k + c)) >> W, in at least 2N+W bits, floor truncation, low 2N bits kept;
    - exact: P = x*y;
    - either mode: z forces P = 0.
- Mode, tag and zero flag travel with their data through every stage; no cross-transaction mixing.
- Approximate mode never exceeds the exact product; powers of two are exact.
- Reset asserted mid-operation discards all in-flight transactions immediately; no partial output appears.
- Simultaneous input accept and output drain in a full pipe: both occur, and occupancy is unchanged.

Decomposition:
- Shared package log_mult_pkg holds:
  - mode constants MODE_APPROX = 0, MODE_EXACT = 1;
  - a function clog2;
  - a stage-payload struct containing k, f, c, z, mode and tag.
- One natural sub-module: lod_enc, a leading-one detector plus fraction truncator parametrised by N and W. It is instantiated twice in S1/S2.

Test Plan:
- N=16, W=6, approx, x=3, y=3 -> out_p = 8 after exactly 4 cycles, with matching out_tag.
- Approx, x=0xFFFF, y=0xFFFF -> 0xFC000000. Exact, same operands -> 0xFFFE0001.
- Approx, x=4, y=8 -> 32 (exact for powers of two). x=0, y=0x1234 in either mode -> 0.
- Stream 8 back-to-back transactions with tags 0..7, hold out_ready = 0 for 5 cycles mid-stream:
  - in_ready drops once all 4 stages are full;
  - outputs stay stable while held;
  - no loss or duplication; tags emerge in order.
- Assert rst while the pipe is full -> out_valid = 0 and out_p = 0 immediately, asynchronous to clk. After release, the first new result appears 4 cycles after acceptance.
- Random 10k operands in both modes against a reference model:
  - exact mode bit-equal;
  - approximate mode equals the Mitchell W-truncated model and is ≤ the exact product.
